// File: rtl/vga_timing_generator_if.sv
// Raster timing bundle: position, blanking qualifier, syncs and strobes,
// driven by vga_timing_generator and consumed by the pixel-colour logic.
interface vga_timing_generator_if;
    int          row;
    int          column;
    logic        display_enable;
    logic        h_sync;
    logic        v_sync;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        output row, column, display_enable, h_sync, v_sync,
               line_start, frame_start, frame_count
    );

    modport slave (
        input  row, column, display_enable, h_sync, v_sync,
               line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_generator.sv
// VGA raster timing source: pixel/line counters with fully registered decode.
// Optional completed-frame counter enabled by macro VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_generator #(
    parameter int H_VISIBLE        = 640,
    parameter int H_FRONT          = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BACK           = 48,
    parameter int V_VISIBLE        = 480,
    parameter int V_FRONT          = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BACK           = 33,
    parameter int SYNC_ACTIVE_HIGH = 0
) (
    input  logic                   vga_clock,
    input  logic                   reset,
    vga_timing_generator_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;

    localparam logic SYNC_IDLE = (SYNC_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

    function automatic logic in_window(input int pos, input int lo, input int len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

    function automatic logic sync_level(input logic active);
        return (SYNC_ACTIVE_HIGH != 0) ? active : !active;
    endfunction

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_wrap;

    int   row_q, row_d;
    int   col_q, col_d;
    logic de_q, de_d;
    logic hs_q, hs_d;
    logic vs_q, vs_d;
    logic ls_q, ls_d;
    logic fs_q, fs_d;

    // Next position, then every output decoded from that same next position
    // so the registered outputs all describe the cycle they are presented in.
    always_comb begin
        h_wrap = (h_q == H_LAST);
        h_d    = h_wrap ? '0 : h_q + HW'(1);
        v_d    = v_q;
        if (h_wrap) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end

        col_d = int'(h_d);
        row_d = int'(v_d);
        de_d  = (col_d < H_VISIBLE) && (row_d < V_VISIBLE);
        hs_d  = sync_level(in_window(col_d, H_SYNC_START, H_SYNC));
        vs_d  = sync_level(in_window(row_d, V_SYNC_START, V_SYNC));
        ls_d  = (h_d == '0);
        fs_d  = (h_d == '0) && (v_d == '0);
    end

    // Reset parks the counters on the last position so release wraps to (0,0).
    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            h_q   <= H_LAST;
            v_q   <= V_LAST;
            row_q <= 0;
            col_q <= 0;
            de_q  <= 1'b0;
            hs_q  <= SYNC_IDLE;
            vs_q  <= SYNC_IDLE;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            row_q <= row_d;
            col_q <= col_d;
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
        end
    end

    assign vga.row            = row_q;
    assign vga.column         = col_q;
    assign vga.display_enable = de_q;
    assign vga.h_sync         = hs_q;
    assign vga.v_sync         = vs_q;
    assign vga.line_start     = ls_q;
    assign vga.frame_start    = fs_q;

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] fc_q, fc_d;
    logic        started_q;

    // The frame_start produced by reset release opens frame 0 and is not counted.
    always_comb begin
        fc_d = fc_q;
        if (fs_d && started_q) begin
            fc_d = fc_q + 16'd1;
        end
    end

    always_ff @(posedge vga_clock) begin
        if (!reset) begin
            fc_q      <= 16'd0;
            started_q <= 1'b0;
        end else begin
            fc_q      <= fc_d;
            started_q <= 1'b1;
        end
    end

    assign vga.frame_count = fc_q;
`else
    assign vga.frame_count = 16'd0;
`endif

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Raster timing source for the VGA display path. Counts pixel and line positions on `vga_clock`, generates horizontal/vertical sync pulses, and drives the `row`, `column` and `display_enable` signals consumed by the pixel-colour logic directly downstream. Also provides line/frame strobes and an optional frame counter for game-tick and animation pacing.

## Interface

Parameters:
- `H_VISIBLE`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: horizontal sync width, pixels
- `H_BACK`, 48: horizontal back porch, pixels
- `V_VISIBLE`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch, lines
- `V_SYNC`, 2: vertical sync width, lines
- `V_BACK`, 33: vertical back porch, lines
- `SYNC_ACTIVE_HIGH`, 0: 0 = sync pulses active-low, 1 = active-high

Ports:
- `vga_clock  input  1`: pixel clock; the block's only clock
- `reset  input  1`: synchronous, active-low reset
- `row  output  int`: current line, 0..V_TOTAL-1
- `column  output  int`: current pixel, 0..H_TOTAL-1
- `display_enable  output  1`: high iff column < H_VISIBLE and row < V_VISIBLE
- `h_sync  output  1`: horizontal sync, polarity per SYNC_ACTIVE_HIGH
- `v_sync  output  1`: vertical sync, polarity per SYNC_ACTIVE_HIGH
- `line_start  output  1`: one-cycle strobe when column == 0
- `frame_start  output  1`: one-cycle strobe when column == 0 and row == 0
- `frame_count  output  16`: completed-frame counter (see Configuration)

## Operation

- H_TOTAL = sum of H_* (800 by default); V_TOTAL = sum of V_* (525 by default).
- The horizontal counter increments every cycle and wraps from H_TOTAL-1 to 0. The vertical counter increments only on horizontal wrap, and wraps from V_TOTAL-1 to 0.
- `h_sync` is asserted for H_VISIBLE+H_FRONT ≤ column < H_VISIBLE+H_FRONT+H_SYNC, which is 656..751 by default.
- `v_sync` is asserted for V_VISIBLE+V_FRONT ≤ row < V_VISIBLE+V_FRONT+V_SYNC, which is 490..491 by default. Its transitions coincide with column == 0.
- `line_start` fires on every line, including blanking lines.
- `frame_start` fires once per frame, in the same cycle as the `line_start` for row 0.
- `row`/`column` are raw counter values; they are not clamped during blanking. Downstream logic qualifies them with `display_enable`.
- Reset:
  - While `reset` = 0 at a rising edge, the internal counters load (H_TOTAL-1, V_TOTAL-1).
  - While held in reset, the outputs are: `row` = 0, `column` = 0, `display_enable` = 0, `line_start` = 0, `frame_start` = 0, `frame_count` = 0, and syncs inactive (1 when active-low).
  - The first edge with `reset` = 1 wraps the counters to (0,0). That cycle presents `display_enable` = 1, `line_start` = 1, `frame_start` = 1, and `frame_count` stays 0.
- Reset asserted mid-frame takes effect at the next edge, regardless of position. No partial-frame state survives.

## Timing

- All outputs are registered and mutually aligned: in any cycle every output describes the same (row, column) position. Combinational decode of the counters onto output ports is not allowed.
- Latency from reset release to the first visible pixel: 1 edge.
- One line = H_TOTAL cycles; one frame = H_TOTAL × V_TOTAL cycles (420 000 by default).
- `frame_count` increments on the edge that produces `frame_start`, excluding the first `frame_start` after reset. It therefore reads N during frame N (0-based), and wraps 65535 → 0 silently.
- Parameter changes require resynthesis; there is no runtime reconfiguration.

## Configuration

- Macro `VGA_TIMING_FRAME_COUNT_EN`:
  - Defined: the 16-bit `frame_count` register is implemented as above.
  - Undefined: no counter register is synthesised, `frame_count` is tied to 16'd0, and all other behaviour is unchanged.

## Test plan

- Hold `reset` = 0 for 5 edges → `row` = 0, `column` = 0, `display_enable` = 0, `h_sync` = `v_sync` = 1, strobes 0, `frame_count` = 0.
- Release reset → first edge shows (0,0), `display_enable` = 1, `frame_start` = 1, `line_start` = 1; edge 640 shows column 640 with `display_enable` = 0.
- Run one line → `h_sync` is 0 exactly at columns 656..751. Column 799 → 0 with `row` 0 → 1 and `line_start` = 1, `frame_start` = 0.
- Run one full frame → `v_sync` is 0 for rows 490..491 only. After (524,799) comes (0,0) with `frame_start` = 1, and `frame_count` = 1 (macro defined) or 0 (macro undefined).
- Assert `reset` = 0 at (300,123) for one edge, then release → outputs take reset values, the next edge restarts at (0,0) with `frame_start` = 1, and `frame_count` = 0.
- Run 65 537 frames with the macro defined → `frame_count` wraps to 0 at the frame after 65535.
